// File: rtl/integer_divider.sv
// Fully pipelined RV32M divider: one prep stage, NUM_ITER radix-4 restoring stages,
// with the last stage's sign/special-case fixup folded into the output registers.
package integer_divider_pkg;
  localparam int XLEN      = 32;
  localparam int REG_WIDTH = 5;
  localparam int NUM_ITER  = XLEN / 2;
  localparam int LATENCY   = NUM_ITER + 1;

  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} div_ctrl_e;

  typedef struct packed {
    div_ctrl_e              div_control;
    logic [REG_WIDTH-1:0]   rd;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
  } ix_div_inf_t;

  // dq shifts dividend bits out of the top while quotient bits fill in at the bottom
  typedef struct packed {
    logic [XLEN-1:0]        rem;
    logic [XLEN-1:0]        dq;
    logic [XLEN-1:0]        dvsr;
    logic [REG_WIDTH-1:0]   rd;
    logic                   is_rem;
    logic                   sign_q;
    logic                   sign_r;
    logic                   dbz;
    logic                   ovf;
  } div_stage_t;
endpackage

// Two restoring shift-subtract steps (2 quotient bits), purely combinational.
module div_iter_stage
  import integer_divider_pkg::*;
(
  input  div_stage_t stage_i,
  output div_stage_t stage_o
);
  logic [XLEN:0] part;

  always_comb begin
    stage_o = stage_i;
    part    = '0;
    for (int s = 0; s < 2; s++) begin
      part       = {stage_o.rem, stage_o.dq[XLEN-1]};
      stage_o.dq = {stage_o.dq[XLEN-2:0], 1'b0};
      if (part >= {1'b0, stage_o.dvsr}) begin
        part          = part - {1'b0, stage_o.dvsr};
        stage_o.dq[0] = 1'b1;
      end
      stage_o.rem = part[XLEN-1:0];
    end
  end
endmodule

module integer_divider
  import integer_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ix_div_valid,
  input  ix_div_inf_t           ix_div_inf,
  output logic                  div_wb_valid,
  output logic [REG_WIDTH-1:0]  div_wb_rd,
  output logic [XLEN-1:0]       div_wb_data
);
  logic [NUM_ITER:0]    vld_pipe_d, vld_pipe_q;
  div_stage_t           stage_d  [NUM_ITER];
  div_stage_t           stage_q  [NUM_ITER];
  div_stage_t           iter_out [NUM_ITER];
  logic [REG_WIDTH-1:0] wb_rd_d, wb_rd_q;
  logic [XLEN-1:0]      wb_data_d, wb_data_q;

  logic            signed_op;
  logic [XLEN-1:0] abs_rs1, abs_rs2;
  logic [XLEN-1:0] quot, rmd;
  div_stage_t      fin;

  assign vld_pipe_d = {vld_pipe_q[NUM_ITER-1:0], ix_div_valid};

  // Prep stage feeds stage_q[0]; each iteration stage feeds the next register.
  always_comb begin
    signed_op = (ix_div_inf.div_control == OP_DIV) || (ix_div_inf.div_control == OP_REM);
    abs_rs1   = (signed_op && ix_div_inf.rs1[XLEN-1]) ? -ix_div_inf.rs1 : ix_div_inf.rs1;
    abs_rs2   = (signed_op && ix_div_inf.rs2[XLEN-1]) ? -ix_div_inf.rs2 : ix_div_inf.rs2;

    stage_d[0].rem    = '0;
    stage_d[0].dq     = abs_rs1;
    stage_d[0].dvsr   = abs_rs2;
    stage_d[0].rd     = ix_div_inf.rd;
    stage_d[0].is_rem = (ix_div_inf.div_control == OP_REM) || (ix_div_inf.div_control == OP_REMU);
    stage_d[0].sign_q = signed_op && (ix_div_inf.rs1[XLEN-1] ^ ix_div_inf.rs2[XLEN-1]);
    stage_d[0].sign_r = signed_op && ix_div_inf.rs1[XLEN-1];
    stage_d[0].dbz    = (ix_div_inf.rs2 == '0);
    stage_d[0].ovf    = signed_op && (ix_div_inf.rs1 == 32'h8000_0000) &&
                        (ix_div_inf.rs2 == 32'hFFFF_FFFF);
    for (int k = 1; k < NUM_ITER; k++) stage_d[k] = iter_out[k-1];
  end

  for (genvar k = 0; k < NUM_ITER; k++) begin : g_iter
    div_iter_stage u_iter (
      .stage_i (stage_q[k]),
      .stage_o (iter_out[k])
    );
  end

  // With a zero divisor the restoring loop leaves |rs1| as remainder, so undoing
  // the sign yields the original rs1 without carrying it down the pipe.
  always_comb begin
    fin  = iter_out[NUM_ITER-1];
    quot = fin.sign_q ? -fin.dq  : fin.dq;
    rmd  = fin.sign_r ? -fin.rem : fin.rem;
    if (fin.dbz) begin
      quot = 32'hFFFF_FFFF;
    end else if (fin.ovf) begin
      quot = 32'h8000_0000;
      rmd  = '0;
    end
    wb_rd_d   = fin.rd;
    wb_data_d = fin.is_rem ? rmd : quot;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  always_ff @(posedge clk) begin
    stage_q   <= stage_d;
    wb_rd_q   <= wb_rd_d;
    wb_data_q <= wb_data_d;
  end

  assign div_wb_valid = vld_pipe_q[NUM_ITER];
  assign div_wb_rd    = wb_rd_q;
  assign div_wb_data  = wb_data_q;
endmodule

// File: tb/tb_integer_divider.sv
// Scoreboard bench for integer_divider: issue pushes expected {rd,data,cycle},
// a negedge monitor pops and compares whenever div_wb_valid is seen.
module tb_integer_divider;
  import integer_divider_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ix_div_valid;
  ix_div_inf_t          ix_div_inf;
  logic                 div_wb_valid;
  logic [REG_WIDTH-1:0] div_wb_rd;
  logic [XLEN-1:0]      div_wb_data;

  always #5 clk = ~clk;

  integer_divider dut (
    .clk          (clk),
    .rst          (rst),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .div_wb_valid (div_wb_valid),
    .div_wb_rd    (div_wb_rd),
    .div_wb_data  (div_wb_data)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          data;
    int                   cyc;
    string                name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] ref_div(div_ctrl_e c, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sbv, sr;
    sa  = a;
    sbv = b;
    case (c)
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sbv;
        return sr;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sbv;
        return sr;
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive one op for one cycle; called at #1 after a posedge.
  task automatic issue(input div_ctrl_e c, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string name,
                       input bit track);
    exp_t e;
    ix_div_valid = 1'b1;
    ix_div_inf   = '{div_control: c, rd: rd, rs1: a, rs2: b};
    if (track) begin
      e.rd = rd; e.data = exp; e.cyc = cyc + LATENCY; e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ix_div_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got=%0d_pending exp=0_pending", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (div_wb_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid got rd=%0d data=%h cyc=%0d exp=no_result",
                 div_wb_rd, div_wb_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (div_wb_rd !== e.rd || div_wb_data !== e.data || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL %s got rd=%0d data=%h cyc=%0d exp rd=%0d data=%h cyc=%0d",
                   e.name, div_wb_rd, div_wb_data, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    div_ctrl_e   c;
    logic [31:0] a, b;
    rst          = 1'b1;
    ix_div_valid = 1'b0;
    ix_div_inf   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", {31'd0, div_wb_valid}, 32'd0);

    issue(OP_DIVU, 5'd5,  32'd100,          32'd7,          32'd14,           "divu_100_7",  1'b1);
    issue(OP_REMU, 5'd5,  32'd100,          32'd7,          32'd2,            "remu_100_7",  1'b1);
    issue(OP_DIV,  5'd1,  32'hFFFF_FFF9,    32'd2,          32'hFFFF_FFFD,    "div_m7_2",    1'b1);
    issue(OP_REM,  5'd2,  32'hFFFF_FFF9,    32'd2,          32'hFFFF_FFFF,    "rem_m7_2",    1'b1);
    issue(OP_DIV,  5'd3,  32'd7,            32'hFFFF_FFFE,  32'hFFFF_FFFD,    "div_7_m2",    1'b1);
    issue(OP_REM,  5'd4,  32'd7,            32'hFFFF_FFFE,  32'd1,            "rem_7_m2",    1'b1);
    issue(OP_DIV,  5'd6,  32'd1234,         32'd0,          32'hFFFF_FFFF,    "div_by0",     1'b1);
    issue(OP_DIVU, 5'd7,  32'd1234,         32'd0,          32'hFFFF_FFFF,    "divu_by0",    1'b1);
    issue(OP_REM,  5'd8,  32'd1234,         32'd0,          32'd1234,         "rem_by0",     1'b1);
    issue(OP_REMU, 5'd9,  32'd1234,         32'd0,          32'd1234,         "remu_by0",    1'b1);
    issue(OP_REM,  5'd10, 32'hFFFF_FB2E,    32'd0,          32'hFFFF_FB2E,    "rem_neg_by0", 1'b1);
    issue(OP_DIV,  5'd11, 32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,    "div_ovf",     1'b1);
    issue(OP_REM,  5'd12, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0,            "rem_ovf",     1'b1);
    issue(OP_DIVU, 5'd13, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0,            "divu_big",    1'b1);
    issue(OP_REMU, 5'd14, 32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000,    "remu_big",    1'b1);
    issue(OP_DIVU, 5'd15, 32'hFFFF_FFFF,    32'd1,          32'hFFFF_FFFF,    "divu_max_1",  1'b1);
    issue(OP_DIV,  5'd16, 32'h8000_0000,    32'd2,          32'hC000_0000,    "div_min_2",   1'b1);
    issue(OP_DIV,  5'd17, 32'hFFFF_FFF8,    32'hFFFF_FFFD,  32'd2,            "div_m8_m3",   1'b1);
    issue(OP_REM,  5'd18, 32'hFFFF_FFF8,    32'hFFFF_FFFD,  32'hFFFF_FFFE,    "rem_m8_m3",   1'b1);
    drain(60);

    for (int i = 0; i < 20; i++) begin
      c = div_ctrl_e'($urandom_range(0, 3));
      a = $urandom;
      case (i % 4)
        0:       b = $urandom_range(1, 300);
        1:       b = $urandom;
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: b = (i == 7) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      issue(c, 5'(i), a, b, ref_div(c, a, b), "rand", 1'b1);
    end
    drain(60);

    // Five in flight, reset at T+8 with an op presented during reset: none may emerge.
    for (int i = 0; i < 5; i++)
      issue(OP_DIVU, 5'(20 + i), 32'd1000 + 32'(i), 32'd3, 32'd0, "flushed", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b1;
    ix_div_valid = 1'b1;
    ix_div_inf   = '{div_control: OP_DIVU, rd: 5'd30, rs1: 32'd9, rs2: 32'd3};
    @(posedge clk); #1;
    rst          = 1'b0;
    ix_div_valid = 1'b0;
    chk("flush_valid", {31'd0, div_wb_valid}, 32'd0);
    issue(OP_REMU, 5'd31, 32'd100, 32'd7, 32'd2, "post_rst", 1'b1);
    drain(40);
    repeat (25) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
